vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_if.sv | 16 +
 rtl/vram_arbiter.sv | 99 +++++++++
 tb/tb_vram_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: requester-side bus of the video SRAM arbiter
interface vram_arbiter_if #(
  parameter int NPORTS = 3,
  parameter int AW = 19
);
  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] we;
  logic [NPORTS*AW-1:0] addr;
  logic [NPORTS*8-1:0] wdata;
  logic wr_mask;
  logic [NPORTS-1:0] ack;
  logic [NPORTS-1:0] rvalid;
  logic [7:0] rdata;
  modport master (output req, we, addr, wdata, wr_mask, input ack, rvalid, rdata);
  modport slave (input req, we, addr, wdata, wr_mask, output ack, rvalid, rdata);
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: NPORTS-way arbiter driving an asynchronous video SRAM with fixed-length strobes
module vram_arbiter #(
  parameter int NPORTS = 3,
  parameter int AW = 19,
  parameter int STROBE_CYC = 2,
  parameter int P0_BURST = 4
) (
  input  logic clk28,
  input  logic rst,
  vram_arbiter_if.slave bus,
  output logic [AW-1:0] va,
  output logic [7:0] vd_o,
  output logic vd_oe,
  input  logic [7:0] vd_i,
  output logic n_vrd,
  output logic n_vwr
);
  localparam int PW = NPORTS > 1 ? $clog2(NPORTS) : 1;
  localparam int NO = NPORTS > 1 ? NPORTS - 1 : 1;
  localparam int CW = $clog2(STROBE_CYC + 1);
  localparam int BW = $clog2(P0_BURST + 1);
  localparam logic [BW-1:0] P0_MAX = BW'(P0_BURST);
  localparam logic [CW-1:0] SC_LAST = CW'(STROBE_CYC - 1);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t r_state, w_next;
  logic [PW-1:0] r_win, r_rr, w_rr_sel, w_win;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_p0_cnt;
  logic [NPORTS-1:0] r_ack, r_rvalid;
  logic [AW-1:0] r_va;
  logic [7:0] r_vd_o, r_rdata;
  logic r_we, r_mask, r_oe, r_nvrd, r_nvwr;
  logic w_rr_hit, w_g0, w_cap;
  assign bus.ack = r_ack;
  assign bus.rvalid = r_rvalid;
  assign bus.rdata = r_rdata;
  assign va = r_va;
  assign vd_o = r_vd_o;
  assign vd_oe = r_oe;
  assign n_vrd = r_nvrd;
  assign n_vwr = r_nvwr;
  // Round-robin over ports 1..NPORTS-1 starting after r_rr; the lowest offset wins.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_sel = r_rr;
    for (int i = NPORTS - 1; i >= 1; i--)
      if (bus.req[(int'(r_rr) + i - 1) % NO + 1]) begin
        w_rr_hit = 1'b1;
        w_rr_sel = PW'((int'(r_rr) + i - 1) % NO + 1);
      end
    w_g0 = bus.req[0] && (r_p0_cnt < P0_MAX || !w_rr_hit);
    w_win = w_g0 ? '0 : w_rr_sel;
    w_cap = (r_state == IDLE || r_state == HOLD) && |bus.req;
    w_next = w_cap ? SETUP :
             r_state == SETUP ? STROBE :
             r_state == STROBE ? (r_cnt == '0 ? HOLD : STROBE) : IDLE;
  end
  always_ff @(posedge clk28 or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // Strobes and drive enable are registered so they are glitch-free and clear asynchronously on reset.
  always_ff @(posedge clk28 or posedge rst)
    if (rst) begin
      r_ack <= '0;
      r_rvalid <= '0;
      r_rdata <= '0;
      r_va <= '0;
      r_vd_o <= '0;
      r_oe <= 1'b0;
      r_nvrd <= 1'b1;
      r_nvwr <= 1'b1;
      r_we <= 1'b0;
      r_mask <= 1'b0;
      r_win <= '0;
      r_cnt <= '0;
      r_p0_cnt <= '0;
      r_rr <= PW'(NPORTS - 1);
    end else begin
      r_ack <= w_cap ? NPORTS'(1) << w_win : '0;
      r_rvalid <= (r_state == STROBE && r_cnt == '0 && !r_we) ? NPORTS'(1) << r_win : '0;
      if (w_cap) begin
        r_va <= bus.addr[w_win * AW +: AW];
        r_vd_o <= bus.wdata[w_win * 8 +: 8];
        r_we <= bus.we[w_win];
        r_mask <= bus.wr_mask;
        r_win <= w_win;
      end
      if (r_state == SETUP) r_cnt <= SC_LAST;
      else if (r_state == STROBE && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (r_state == STROBE && r_cnt == '0 && !r_we) r_rdata <= vd_i;
      r_nvrd <= !(w_next == STROBE && !r_we);
      r_nvwr <= !(w_next == STROBE && r_we && !r_mask);
      r_oe <= w_next == IDLE ? 1'b0 : w_cap ? bus.we[w_win] : r_we;
      if (!w_rr_hit) r_p0_cnt <= '0;
      else if (w_cap && w_g0) r_p0_cnt <= r_p0_cnt == P0_MAX ? r_p0_cnt : r_p0_cnt + 1'b1;
      else if (w_cap) r_p0_cnt <= '0;
      if (w_cap && !w_g0) r_rr <= w_rr_sel;
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vector table, arbitration sequences, reset abort and random invariant sweep
module tb_vram_arbiter;
  localparam int AW = 19;
  localparam int SC = 2;
  logic clk28 = 1'b0;
  logic rst = 1'b1;
  always #18 clk28 = ~clk28;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk28) cyc <= cyc + 1;
  vram_arbiter_if #(.NPORTS(3), .AW(AW)) b3();
  vram_arbiter_if #(.NPORTS(1), .AW(AW)) b1();
  vram_arbiter_if #(.NPORTS(5), .AW(AW)) b5();
  logic [AW-1:0] va3, va1, va5;
  logic [7:0] vdo3, vdo1, vdo5, vdi3, vdi1, vdi5;
  logic oe3, oe1, oe5, nrd3, nrd1, nrd5, nwr3, nwr1, nwr5;
  vram_arbiter #(.NPORTS(3), .AW(AW)) dut3 (.clk28(clk28), .rst(rst), .bus(b3), .va(va3), .vd_o(vdo3),
    .vd_oe(oe3), .vd_i(vdi3), .n_vrd(nrd3), .n_vwr(nwr3));
  vram_arbiter #(.NPORTS(1), .AW(AW)) dut1 (.clk28(clk28), .rst(rst), .bus(b1), .va(va1), .vd_o(vdo1),
    .vd_oe(oe1), .vd_i(vdi1), .n_vrd(nrd1), .n_vwr(nwr1));
  vram_arbiter #(.NPORTS(5), .AW(AW)) dut5 (.clk28(clk28), .rst(rst), .bus(b5), .va(va5), .vd_o(vdo5),
    .vd_oe(oe5), .vd_i(vdi5), .n_vrd(nrd5), .n_vwr(nwr5));
  logic [7:0] mem [0:(1<<AW)-1];
  logic ld_en = 1'b0;
  logic [AW-1:0] ld_a = '0;
  logic [7:0] ld_d = '0;
  assign vdi3 = mem[va3];
  always @(posedge clk28)
    if (ld_en) mem[ld_a] <= ld_d;
    else if (!nwr3) mem[va3] <= vdo3;
  typedef struct {
    int port;
    logic wr;
    logic [AW-1:0] a;
    logic [7:0] d;
    logic m;
    logic [7:0] exp;
  } vec_t;
  vec_t tv [8];
  logic [7:0] g_ack [16];
  int g_cyc [16];
  int got;
  logic [AW-1:0] pva3, pva1, pva5;
  logic pnrd3, pnrd1, pnrd5, pnwr3, pnwr1, pnwr5;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk28);
    ld_en = 1'b1;
    ld_a = a;
    ld_d = d;
    @(negedge clk28);
    ld_en = 1'b0;
  endtask
  task automatic access(input vec_t v);
    logic [2:0] oh;
    oh = 3'(1 << v.port);
    @(negedge clk28);
    b3.req = oh;
    b3.we = v.wr ? oh : 3'b0;
    b3.addr[v.port*AW +: AW] = v.a;
    b3.wdata[v.port*8 +: 8] = v.d;
    b3.wr_mask = v.m;
    @(negedge clk28);
    chk("setup_ack", 32'(b3.ack), 32'(oh));
    chk("setup_va", 32'(va3), 32'(v.a));
    chk("setup_strobes", 32'({nrd3, nwr3}), 32'(2'b11));
    chk("setup_oe", 32'(oe3), 32'(v.wr));
    b3.req = '0;
    for (int i = 0; i < SC; i++) begin
      @(negedge clk28);
      chk("strobe_levels", 32'({nrd3, nwr3}), 32'({v.wr, !(v.wr && !v.m)}));
      chk("strobe_oe", 32'(oe3), 32'(v.wr));
      chk("strobe_ack", 32'(b3.ack), 32'(0));
      if (v.wr) chk("strobe_vd_o", 32'(vdo3), 32'(v.d));
    end
    @(negedge clk28);
    chk("hold_rvalid", 32'(b3.rvalid), 32'(v.wr ? 3'b0 : oh));
    if (!v.wr) chk("hold_rdata", 32'(b3.rdata), 32'(v.exp));
    chk("hold_strobes", 32'({nrd3, nwr3}), 32'(2'b11));
    chk("hold_va", 32'(va3), 32'(v.a));
    chk("hold_oe", 32'(oe3), 32'(v.wr));
    @(negedge clk28);
    chk("idle_outputs", 32'({b3.ack, b3.rvalid, oe3, nrd3, nwr3}), 32'(9'b000_000_0_11));
  endtask
  task automatic collect(input int n, input logic sel);
    int w;
    logic [7:0] a;
    w = 0;
    got = 0;
    while (got < n && w < 100) begin
      @(negedge clk28);
      w++;
      a = sel ? 8'(b5.ack) : 8'(b3.ack);
      if (a != 0) begin
        g_ack[got] = a;
        g_cyc[got] = cyc;
        got++;
      end
    end
    chk("grant_count", 32'(got), 32'(n));
  endtask
  task automatic inv(input string t, input logic nrd, input logic nwr, input logic oe, input logic [7:0] ack,
                     input logic [7:0] rv, input logic [AW-1:0] a, input logic [AW-1:0] pa, input logic pnrd,
                     input logic pnwr);
    chk({t, "_strobe_excl"}, 32'(!nrd && !nwr), 32'(0));
    chk({t, "_oe_during_rd"}, 32'(oe && !nrd), 32'(0));
    chk({t, "_ack_onehot"}, 32'($countones(ack) > 1), 32'(0));
    chk({t, "_rvalid_onehot"}, 32'($countones(rv) > 1), 32'(0));
    chk({t, "_va_at_strobe_fall"}, 32'(((pnrd && !nrd) || (pnwr && !nwr)) && a != pa), 32'(0));
  endtask
  task automatic drive_rand();
    b3.req = 3'($urandom);
    b3.we = 3'($urandom);
    b3.wr_mask = 1'($urandom);
    for (int p = 0; p < 3; p++) begin
      b3.addr[p*AW +: AW] = AW'($urandom);
      b3.wdata[p*8 +: 8] = 8'($urandom);
    end
    b1.req = 1'($urandom);
    b1.we = 1'($urandom);
    b1.wr_mask = 1'($urandom);
    b1.addr = AW'($urandom);
    b1.wdata = 8'($urandom);
    b5.req = 5'($urandom);
    b5.we = 5'($urandom);
    b5.wr_mask = 1'($urandom);
    for (int p = 0; p < 5; p++) begin
      b5.addr[p*AW +: AW] = AW'($urandom);
      b5.wdata[p*8 +: 8] = 8'($urandom);
    end
    vdi1 = 8'($urandom);
    vdi5 = 8'($urandom);
  endtask
  initial begin
    logic [7:0] starve_exp [10];
    logic [7:0] rr_exp [4];
    logic [7:0] rr5_exp [4];
    int n;
    starve_exp = '{8'h1, 8'h1, 8'h1, 8'h1, 8'h2, 8'h1, 8'h1, 8'h1, 8'h1, 8'h2};
    rr_exp = '{8'h2, 8'h4, 8'h2, 8'h4};
    rr5_exp = '{8'h2, 8'h4, 8'h8, 8'h10};
    tv[0] = '{1, 1'b0, 19'h1ABCD, 8'h00, 1'b0, 8'h5A};
    tv[1] = '{0, 1'b1, 19'h00010, 8'hC3, 1'b0, 8'h00};
    tv[2] = '{0, 1'b0, 19'h00010, 8'h00, 1'b0, 8'hC3};
    tv[3] = '{2, 1'b1, 19'h12345, 8'h33, 1'b1, 8'h00};
    tv[4] = '{2, 1'b0, 19'h12345, 8'h00, 1'b0, 8'h99};
    tv[5] = '{1, 1'b1, 19'h7FFFF, 8'hFF, 1'b0, 8'h00};
    tv[6] = '{1, 1'b0, 19'h7FFFF, 8'h00, 1'b0, 8'hFF};
    tv[7] = '{2, 1'b0, 19'h00010, 8'h00, 1'b0, 8'hC3};
    b3.req = '0; b3.we = '0; b3.addr = '0; b3.wdata = '0; b3.wr_mask = 1'b0;
    b1.req = '0; b1.we = '0; b1.addr = '0; b1.wdata = '0; b1.wr_mask = 1'b0;
    b5.req = '0; b5.we = '0; b5.addr = '0; b5.wdata = '0; b5.wr_mask = 1'b0;
    vdi1 = 8'h6C;
    vdi5 = 8'h00;
    load(19'h1ABCD, 8'h5A);
    load(19'h12345, 8'h99);
    chk("rst_strobes", 32'({nrd3, nwr3}), 32'(2'b11));
    chk("rst_oe", 32'(oe3), 32'(0));
    chk("rst_ack_rvalid", 32'({b3.ack, b3.rvalid}), 32'(0));
    chk("rst_rdata", 32'(b3.rdata), 32'(0));
    chk("rst_va_vd_o", 32'({va3, vdo3}), 32'(0));
    chk("rst_state", 32'(dut3.r_state), 32'(0));
    chk("rst_rr3", 32'(dut3.r_rr), 32'(2));
    chk("rst_rr5", 32'(dut5.r_rr), 32'(4));
    chk("rst_p0_cnt", 32'(dut3.r_p0_cnt), 32'(0));
    @(negedge clk28);
    rst = 1'b0;
    foreach (tv[i]) access(tv[i]);
    chk("masked_mem", 32'(mem[19'h12345]), 32'(8'h99));
    chk("written_mem", 32'(mem[19'h7FFFF]), 32'(8'hFF));
    @(negedge clk28);
    b3.we = '0;
    b3.req = 3'b110;
    collect(4, 1'b0);
    b3.req = '0;
    for (int i = 0; i < 4; i++) chk("rr_order", 32'(g_ack[i]), 32'(rr_exp[i]));
    for (int i = 1; i < 4; i++) chk("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'(SC + 2));
    repeat (8) @(negedge clk28);
    b3.req = 3'b011;
    collect(10, 1'b0);
    b3.req = '0;
    for (int i = 0; i < 10; i++) chk("starve_order", 32'(g_ack[i]), 32'(starve_exp[i]));
    repeat (8) @(negedge clk28);
    b3.req = 3'b010;
    b3.we = 3'b010;
    b3.wr_mask = 1'b0;
    b3.addr[AW +: AW] = 19'h00100;
    b3.wdata[8 +: 8] = 8'hAA;
    n = 0;
    do begin
      @(negedge clk28);
      n++;
    end while (!b3.ack[1] && n < 20);
    chk("rstwr_ack", 32'(b3.ack), 32'(3'b010));
    b3.req = '0;
    n = 0;
    while (nwr3 && n < 20) begin
      @(negedge clk28);
      n++;
    end
    chk("rstwr_nvwr_low", 32'(nwr3), 32'(0));
    #4 rst = 1'b1;
    #1;
    chk("rstwr_nvwr", 32'(nwr3), 32'(1));
    chk("rstwr_oe", 32'(oe3), 32'(0));
    chk("rstwr_nvrd", 32'(nrd3), 32'(1));
    chk("rstwr_state", 32'(dut3.r_state), 32'(0));
    chk("rstwr_regs", 32'({va3, vdo3}), 32'(0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk28);
      chk("rstwr_rvalid", 32'(b3.rvalid), 32'(0));
      chk("rstwr_strobes", 32'({nrd3, nwr3}), 32'(2'b11));
    end
    @(posedge clk28);
    #2 rst = 1'b0;
    access(tv[0]);
    @(negedge clk28);
    b1.req = 1'b1;
    b1.we = 1'b0;
    b1.addr = 19'h00042;
    @(negedge clk28);
    chk("np1_ack", 32'(b1.ack), 32'(1));
    chk("np1_va", 32'(va1), 32'(19'h00042));
    b1.req = 1'b0;
    @(negedge clk28);
    chk("np1_nvrd", 32'(nrd1), 32'(0));
    repeat (2) @(negedge clk28);
    chk("np1_rvalid", 32'(b1.rvalid), 32'(1));
    chk("np1_rdata", 32'(b1.rdata), 32'(8'h6C));
    @(negedge clk28);
    b5.we = '0;
    b5.req = 5'b11110;
    collect(4, 1'b1);
    b5.req = '0;
    for (int i = 0; i < 4; i++) chk("np5_rr_order", 32'(g_ack[i]), 32'(rr5_exp[i]));
    repeat (8) @(negedge clk28);
    pva3 = va3; pva1 = va1; pva5 = va5;
    pnrd3 = nrd3; pnrd1 = nrd1; pnrd5 = nrd5;
    pnwr3 = nwr3; pnwr1 = nwr1; pnwr5 = nwr5;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk28);
      inv("np3", nrd3, nwr3, oe3, 8'(b3.ack), 8'(b3.rvalid), va3, pva3, pnrd3, pnwr3);
      inv("np1", nrd1, nwr1, oe1, 8'(b1.ack), 8'(b1.rvalid), va1, pva1, pnrd1, pnwr1);
      inv("np5", nrd5, nwr5, oe5, 8'(b5.ack), 8'(b5.rvalid), va5, pva5, pnrd5, pnwr5);
      pva3 = va3; pva1 = va1; pva5 = va5;
      pnrd3 = nrd3; pnrd1 = nrd1; pnrd5 = nrd5;
      pnwr3 = nwr3; pnwr1 = nwr1; pnwr5 = nwr5;
      drive_rand();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
